// File: rtl/mem_d1_host_bridge.sv
// mem_d1_host_bridge: std_mem_d1-style word array shared between a kernel port
// and a host load/unload port. A two-state ownership FSM decides which side may
// touch the array. Any misuse sets a sticky err flag that only reset clears.
module mem_d1_host_bridge #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 2,
    parameter int IDX_SIZE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                write_en,
    output logic [WIDTH-1:0]    read_data,
    output logic                done,
    input  logic                kernel_mode,
    output logic                kernel_owned,
    input  logic                host_valid,
    output logic                host_ready,
    input  logic                host_we,
    input  logic [IDX_SIZE-1:0] host_addr,
    input  logic [WIDTH-1:0]    host_wdata,
    output logic                host_rvalid,
    input  logic                host_rready,
    output logic [WIDTH-1:0]    host_rdata,
    output logic [15:0]         write_count,
    output logic                err
);

    localparam logic [0:0] ST_HOST   = 1'b0;
    localparam logic [0:0] ST_KERNEL = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] mem [SIZE];

    logic             k_in_rng, h_in_rng;
    logic             host_acc, k_wr, h_wr, err_evt;
    logic [WIDTH-1:0] k_word, h_word;

    assign k_in_rng     = 32'(addr0) < 32'(SIZE);
    assign h_in_rng     = 32'(host_addr) < 32'(SIZE);
    assign kernel_owned = (state == ST_KERNEL);

    // A pending read that is not being drained stalls new host requests.
    assign host_ready = (state == ST_HOST) & ~kernel_mode & (~host_rvalid | host_rready);
    assign host_acc   = host_valid & host_ready;

    // Ownership is exclusive, so these two write enables are never active together.
    assign k_wr = write_en & kernel_owned & k_in_rng;
    assign h_wr = host_acc & host_we & h_in_rng;

    // A kernel write outside KERNEL, an out-of-range access from either side, and a
    // host request while the kernel owns the array are all flagged.
    assign err_evt = (write_en & ~kernel_owned)
                   | (write_en & kernel_owned & ~k_in_rng)
                   | (host_acc & ~h_in_rng)
                   | (host_valid & kernel_owned);

    // Decoded read muxes. A loop is used instead of a direct index so that an
    // address of IDX_SIZE bits never indexes past a smaller array.
    always_comb begin
        k_word = '0;
        h_word = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (32'(addr0) == 32'(i))     k_word = mem[i];
            if (32'(host_addr) == 32'(i)) h_word = mem[i];
        end
    end

    assign read_data = (kernel_owned && k_in_rng) ? k_word : '0;

    // Array storage has no reset, so host-loaded contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (k_wr && 32'(addr0) == 32'(i))
                mem[i] <= write_data;
            else if (h_wr && 32'(host_addr) == 32'(i))
                mem[i] <= host_wdata;
        end
    end

    // Ownership FSM. An outstanding or newly accepted host read holds off the kernel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HOST;
        end else begin
            case (state)
                ST_HOST:   if (kernel_mode && !host_rvalid && !host_acc) state <= ST_KERNEL;
                ST_KERNEL: if (!kernel_mode && !write_en)                state <= ST_HOST;
                default:   state <= ST_HOST;
            endcase
        end
    end

    // Kernel write completion pulse and saturating write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done        <= 1'b0;
            write_count <= '0;
        end else begin
            done <= k_wr;
            if (k_wr && write_count != 16'hFFFF)
                write_count <= write_count + 16'd1;
        end
    end

    // Host read return. The data register only loads on an accepted read, so it
    // holds while the consumer stalls. An out-of-range read returns zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else if (host_acc && !host_we) begin
            host_rvalid <= 1'b1;
            host_rdata  <= h_in_rng ? h_word : '0;
        end else if (host_rready) begin
            host_rvalid <= 1'b0;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       err <= 1'b0;
        else if (err_evt) err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_d1_host_bridge.sv
// Bench for mem_d1_host_bridge. Instance a uses the default parameters and
// instance b uses SIZE=1 to reach out-of-range addresses. Both instances share
// their inputs. Host read data goes through a scoreboard queue.
module tb_mem_d1_host_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  addr0;
    logic [31:0] write_data;
    logic        write_en;
    logic        kernel_mode;
    logic        host_valid;
    logic        host_we;
    logic [0:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_rready;

    logic [31:0] a_read_data, b_read_data, a_host_rdata, b_host_rdata;
    logic        a_done, b_done, a_owned, b_owned, a_ready, b_ready;
    logic        a_rvalid, b_rvalid, a_err, b_err;
    logic [15:0] a_count, b_count;

    int          n_chk = 0;
    int          n_bad = 0;
    logic        mon_b = 1'b0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_d1_host_bridge #(.WIDTH(32), .SIZE(2), .IDX_SIZE(1)) dut_a (
        .clk(clk), .reset(reset), .addr0(addr0), .write_data(write_data),
        .write_en(write_en), .read_data(a_read_data), .done(a_done),
        .kernel_mode(kernel_mode), .kernel_owned(a_owned), .host_valid(host_valid),
        .host_ready(a_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(a_rvalid), .host_rready(host_rready),
        .host_rdata(a_host_rdata), .write_count(a_count), .err(a_err)
    );

    mem_d1_host_bridge #(.WIDTH(32), .SIZE(1), .IDX_SIZE(1)) dut_b (
        .clk(clk), .reset(reset), .addr0(addr0), .write_data(write_data),
        .write_en(write_en), .read_data(b_read_data), .done(b_done),
        .kernel_mode(kernel_mode), .kernel_owned(b_owned), .host_valid(host_valid),
        .host_ready(b_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rvalid(b_rvalid), .host_rready(host_rready),
        .host_rdata(b_host_rdata), .write_count(b_count), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [0:0] a, input logic [31:0] d);
        host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1 chk("hw_ready", 32'(a_ready), 32'd1);
        tick();
        host_valid = 1'b0; host_we = 1'b0;
    endtask

    // Issues a read on instance a and records the value it must return.
    task automatic host_rd(input logic [0:0] a, input logic [31:0] exp);
        host_valid = 1'b1; host_we = 1'b0; host_addr = a;
        #1 chk("hr_ready", 32'(a_ready), 32'd1);
        exp_q.push_back(exp);
        tick();
        host_valid = 1'b0;
    endtask

    // Scoreboard: pop the expected word whenever the host consumes read data.
    always @(negedge clk) begin
        if (reset && host_rready && (mon_b ? b_rvalid : a_rvalid)) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                   chk("sb_rdata", mon_b ? b_host_rdata : a_host_rdata, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; addr0 = '0; write_data = '0; write_en = 1'b0; kernel_mode = 1'b0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_rready = 1'b0;
        #3;
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_done",   32'(a_done),   32'd0);
        chk("rst_err",    32'(a_err),    32'd0);
        chk("rst_owned",  32'(a_owned),  32'd0);
        chk("rst_count",  32'(a_count),  32'd0);
        chk("rst_rdata",  a_host_rdata,  32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: host load and read back, including back-to-back reads
        host_wr(1'b0, 32'hFFFF_FFF6);
        host_wr(1'b1, 32'h0000_1234);
        host_rd(1'b0, 32'hFFFF_FFF6);
        chk("t1_rvalid", 32'(a_rvalid), 32'd1);
        host_rready = 1'b1;
        tick();
        chk("t1_rvalid_clr", 32'(a_rvalid), 32'd0);
        host_rd(1'b0, 32'hFFFF_FFF6);
        host_rd(1'b1, 32'h0000_1234);
        tick();
        chk("t1_b2b_clr", 32'(a_rvalid), 32'd0);
        host_rready = 1'b0;

        // 2: kernel ownership, reads, single and consecutive writes
        kernel_mode = 1'b1;
        tick();
        chk("t2_owned", 32'(a_owned), 32'd1);
        addr0 = 1'b0;
        #1 chk("t2_rd0", a_read_data, 32'hFFFF_FFF6);
        addr0 = 1'b1;
        #1 chk("t2_rd1", a_read_data, 32'h0000_1234);
        addr0 = 1'b0; write_data = 32'h5; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        chk("t2_done", 32'(a_done), 32'd1);
        chk("t2_cnt", 32'(a_count), 32'd1);
        tick();
        chk("t2_done_off", 32'(a_done), 32'd0);
        addr0 = 1'b1; write_data = 32'h7; write_en = 1'b1;
        tick();
        write_data = 32'h8;
        chk("t2_done_a", 32'(a_done), 32'd1);
        chk("t2_cnt_a", 32'(a_count), 32'd2);
        tick();
        write_en = 1'b0;
        chk("t2_done_b", 32'(a_done), 32'd1);
        chk("t2_cnt_b", 32'(a_count), 32'd3);
        tick();
        chk("t2_done_end", 32'(a_done), 32'd0);
        chk("t2_rd1_new", a_read_data, 32'h8);
        chk("t2_err", 32'(a_err), 32'd0);

        // 3: back to host, stalled read holds its data
        kernel_mode = 1'b0; addr0 = 1'b0;
        tick();
        chk("t3_owned", 32'(a_owned), 32'd0);
        #1 chk("t3_rd_zero", a_read_data, 32'd0);
        host_rd(1'b0, 32'h5);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_v", 32'(a_rvalid), 32'd1);
            chk("t3_hold_d", a_host_rdata, 32'h5);
            tick();
        end
        host_rready = 1'b1;
        tick();
        host_rready = 1'b0;
        chk("t3_drained", 32'(a_rvalid), 32'd0);

        // 4: kernel write while host owns the array
        addr0 = 1'b0; write_data = 32'hDEAD; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        chk("t4_no_done", 32'(a_done), 32'd0);
        chk("t4_err", 32'(a_err), 32'd1);
        chk("t4_cnt", 32'(a_count), 32'd3);
        tick(); tick();
        chk("t4_err_sticky", 32'(a_err), 32'd1);
        host_rready = 1'b1;
        host_rd(1'b0, 32'h5);
        tick();
        host_rready = 1'b0;

        // 5: asynchronous reset with a read in flight
        host_rd(1'b0, 32'h5);
        chk("t5_pre_rvalid", 32'(a_rvalid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rvalid", 32'(a_rvalid), 32'd0);
        chk("t5_done",   32'(a_done),   32'd0);
        chk("t5_cnt",    32'(a_count),  32'd0);
        chk("t5_err",    32'(a_err),    32'd0);
        chk("t5_rdata",  a_host_rdata,  32'd0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b1;
        host_rready = 1'b1;
        host_rd(1'b0, 32'h5);
        tick();
        host_rready = 1'b0;

        // host request while the kernel owns the array
        kernel_mode = 1'b1;
        tick();
        chk("t5k_owned", 32'(a_owned), 32'd1);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 1'b0;
        #1 chk("t5k_ready", 32'(a_ready), 32'd0);
        tick();
        host_valid = 1'b0;
        chk("t5k_err", 32'(a_err), 32'd1);
        chk("t5k_rvalid", 32'(a_rvalid), 32'd0);
        kernel_mode = 1'b0;
        tick();

        // 6: SIZE=1 instance, out-of-range read and delayed ownership switch
        reset = 1'b0; #1 reset = 1'b1;
        mon_b = 1'b1;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 1'b1;
        #1 chk("t6_ready", 32'(b_ready), 32'd1);
        exp_q.push_back(32'd0);
        tick();
        host_valid = 1'b0; kernel_mode = 1'b1;
        chk("t6_err", 32'(b_err), 32'd1);
        chk("t6_rvalid", 32'(b_rvalid), 32'd1);
        chk("t6_rdata", b_host_rdata, 32'd0);
        tick();
        chk("t6_wait_a", 32'(b_owned), 32'd0);
        tick();
        chk("t6_wait_b", 32'(b_owned), 32'd0);
        host_rready = 1'b1;
        tick();
        host_rready = 1'b0;
        chk("t6_drain_edge", 32'(b_owned), 32'd0);
        chk("t6_drained", 32'(b_rvalid), 32'd0);
        tick();
        chk("t6_owned", 32'(b_owned), 32'd1);
        addr0 = 1'b1; write_data = 32'h9; write_en = 1'b1;
        #1 chk("t6_rd_oob", b_read_data, 32'd0);
        tick();
        write_en = 1'b0;
        chk("t6_oob_done", 32'(b_done), 32'd0);
        chk("t6_oob_cnt", 32'(b_count), 32'd0);
        addr0 = 1'b0;
        #1 chk("t6_rd0", b_read_data, 32'h5);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
